// File: rtl/fp32_fixed_pkg.sv
// FP32 field layout and the stage-1 payload shared by the FP32-to-fixed converter and its pipeline.
package fp32_fixed_pkg;

  localparam int SIGN_POS = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int EXP_W    = 8;
  localparam int MAN_MSB  = 22;
  localparam int MAN_W    = 23;
  localparam int SIG_W    = MAN_W + 1;

  localparam logic [EXP_W-1:0] EXP_BIAS    = 8'd127;
  localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

  // Aligned, rounded magnitude plus the flags S2 needs to clamp and negate.
  typedef struct packed {
    logic        sign;
    logic [31:0] mag;
    logic        big;
    logic        inf;
    logic        nan;
    logic        last;
  } s1_t;

endpackage

// File: rtl/fp32_fixed_convert.sv
// Combinational FP32 decode, mantissa alignment and round-half-away-from-zero to FRAC_BITS.
// No latency, no flow control; sits in front of the S1 register.
module fp32_fixed_convert
  import fp32_fixed_pkg::*;
#(
  parameter int FRAC_BITS = 16
) (
  input  logic [31:0] data,
  input  logic        last,
  output s1_t         payload
);

  // Left shift applied to the 24-bit significand to land on the output LSB grid.
  localparam logic signed [9:0] SH_OFS = 10'(FRAC_BITS - int'(EXP_BIAS) - MAN_W);
  localparam logic signed [9:0] BIG_SH = 10'(32 - SIG_W);
  localparam logic signed [9:0] MAX_RS = 10'sd25;

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic [SIG_W-1:0] sig;
  logic signed [9:0] sh;
  logic signed [9:0] rs;
  logic [4:0]        rsc;
  logic [SIG_W:0]    rnd;

  always_comb begin
    exp_f   = data[EXP_MSB:EXP_LSB];
    man_f   = data[MAN_MSB:0];
    sig     = {1'b1, man_f};
    sh      = $signed({2'b00, exp_f}) + SH_OFS;
    rs      = -sh;
    rsc     = 5'd0;
    rnd     = '0;
    payload = '0;
    payload.sign = data[SIGN_POS];
    payload.last = last;

    if (exp_f == EXP_SPECIAL) begin
      payload.inf = (man_f == '0);
      payload.nan = (man_f != '0);
    end else if (exp_f != '0) begin
      if (!sh[9]) begin
        // Shifting a normalised significand this far already exceeds any legal clamp.
        if (sh >= BIG_SH) payload.big = 1'b1;
        else              payload.mag = {8'b0, sig} << sh[2:0];
      end else begin
        // Beyond 25 right shifts the half-LSB exceeds the significand, so the result is 0 anyway.
        rsc = (rs > MAX_RS) ? 5'd25 : rs[4:0];
        rnd = {1'b0, sig} + (25'd1 << (rsc - 5'd1));
        payload.mag = {7'b0, rnd >> rsc};
      end
    end
  end

endmodule

// File: rtl/fp32_to_fixed_stage.sv
// FP32 to saturated Q(32-FRAC_BITS).FRAC_BITS converter with saturation event counter.
// Two-stage valid/ready pipeline, 2-cycle latency, full backpressure via a combinational ready path.
module fp32_to_fixed_stage
  import fp32_fixed_pkg::*;
#(
  parameter int FRAC_BITS = 16,
  parameter int CLAMP_INT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic [31:0] input_data,
  input  logic        last_in,
  output logic        valid_out,
  input  logic        ready_in,
  output logic [31:0] output_data,
  output logic        last_out,
  output logic        sat_out,
  input  logic        clr_cnt,
  output logic [15:0] sat_count
);

  localparam logic [31:0] CLAMP = 32'(CLAMP_INT) << FRAC_BITS;

  s1_t         conv;
  s1_t         p1;
  logic        v1;
  logic        v2;
  logic        s1_load;
  logic        s2_load;
  logic [31:0] mag_cl;
  logic [31:0] data_nxt;
  logic        sat_nxt;

  fp32_fixed_convert #(
    .FRAC_BITS(FRAC_BITS)
  ) u_convert (
    .data    (input_data),
    .last    (last_in),
    .payload (conv)
  );

  // An empty S2 always pulls from S1, so bubbles never block the pipe.
  assign s2_load   = !v2 || ready_in;
  assign s1_load   = !v1 || s2_load;
  assign ready_out = s1_load;
  assign valid_out = v2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      p1 <= '0;
    end else if (s1_load) begin
      v1 <= valid_in;
      if (valid_in) p1 <= conv;
    end
  end

  always_comb begin
    sat_nxt = 1'b0;
    mag_cl  = p1.mag;
    if (p1.nan) begin
      mag_cl  = '0;
      sat_nxt = 1'b1;
    end else if (p1.inf || p1.big || (p1.mag > CLAMP)) begin
      mag_cl  = CLAMP;
      sat_nxt = 1'b1;
    end
    data_nxt = p1.sign ? (32'd0 - mag_cl) : mag_cl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2          <= 1'b0;
      output_data <= '0;
      last_out    <= 1'b0;
      sat_out     <= 1'b0;
    end else if (s2_load) begin
      v2 <= v1;
      if (v1) begin
        output_data <= data_nxt;
        last_out    <= p1.last;
        sat_out     <= sat_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (clr_cnt) begin
      sat_count <= '0;
    end else if (v2 && ready_in && sat_out && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fp32_to_fixed_stage.sv
// Directed bench for fp32_to_fixed_stage (FRAC_BITS=16, CLAMP_INT=8) with an expected-value queue.
module tb_fp32_to_fixed_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] input_data;
  logic        last_in;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] output_data;
  logic        last_out;
  logic        sat_out;
  logic        clr_cnt;
  logic [15:0] sat_count;

  int total = 0;
  int bad   = 0;
  int occ;
  logic bp_done;

  typedef struct {
    logic [31:0] d;
    logic        s;
    logic        l;
  } exp_t;
  exp_t q[$];

  // Hand-computed vectors: input, expected Q16.16 output, expected sat flag.
  logic [31:0] vin [0:19] = '{
    32'h3F800000, 32'hC0200000, 32'h42C80000, 32'h41000000, 32'hFF800000,
    32'h7FC00000, 32'h37000000, 32'h36800000, 32'h00000001, 32'h3F000000,
    32'hC1000000, 32'h40490FDB, 32'h37C00000, 32'hB7C00000, 32'h41000008,
    32'h41000001, 32'h7F7FFFFF, 32'h80000000, 32'hC2C80000, 32'h40000000};
  logic [31:0] vexp [0:19] = '{
    32'h00010000, 32'hFFFD8000, 32'h00080000, 32'h00080000, 32'hFFF80000,
    32'h00000000, 32'h00000001, 32'h00000000, 32'h00000000, 32'h00008000,
    32'hFFF80000, 32'h0003243F, 32'h00000002, 32'hFFFFFFFE, 32'h00080000,
    32'h00080000, 32'h00080000, 32'h00000000, 32'hFFF80000, 32'h00020000};
  logic vsat [0:19] = '{
    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  fp32_to_fixed_stage #(
    .FRAC_BITS(16),
    .CLAMP_INT(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .input_data  (input_data),
    .last_in     (last_in),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .output_data (output_data),
    .last_out    (last_out),
    .sat_out     (sat_out),
    .clr_cnt     (clr_cnt),
    .sat_count   (sat_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Elements held in the pipe, from observed handshakes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ <= 0;
    else occ <= occ + ((valid_in && ready_out) ? 1 : 0) - ((valid_out && ready_in) ? 1 : 0);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_out", 32'(ready_out), 32'(!(occ == 2 && !ready_in)));
      if (valid_out && ready_in) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 32'(valid_out), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("data", output_data, e.d);
          chk("sat", 32'(sat_out), 32'(e.s));
          chk("last", 32'(last_out), 32'(e.l));
        end
      end
    end
  end

  task automatic drive(input int idx, input logic lst);
    logic done;
    done       = 1'b0;
    valid_in   = 1'b1;
    input_data = vin[idx];
    last_in    = lst;
    for (int g = 0; g < 300 && !done; g++) begin
      @(negedge clk);
      if (ready_out) begin
        q.push_back('{vexp[idx], vsat[idx], lst});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("drive_timeout", 32'(ready_out), 32'd1);
  endtask

  task automatic drain();
    logic done;
    done     = 1'b0;
    valid_in = 1'b0;
    last_in  = 1'b0;
    for (int g = 0; g < 500 && !done; g++) begin
      @(posedge clk);
      #1;
      if (q.size() == 0) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    valid_in   = 1'b0;
    input_data = '0;
    last_in    = 1'b0;
    ready_in   = 1'b1;
    clr_cnt    = 1'b0;
    bp_done    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_data", output_data, 32'd0);
    chk("rst_last", 32'(last_out), 32'd0);
    chk("rst_sat", 32'(sat_out), 32'd0);
    chk("rst_cnt", 32'(sat_count), 32'd0);
    chk("rst_ready", 32'(ready_out), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: output valid in the second cycle after the input cycle.
    for (int k = 0; k < 2; k++) begin
      q.push_back('{vexp[k], vsat[k], 1'b0});
      valid_in   = 1'b1;
      input_data = vin[k];
      last_in    = 1'b0;
      @(negedge clk);
      chk("lat_c0", 32'(valid_out), 32'd0);
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      @(negedge clk);
      chk("lat_c1", 32'(valid_out), 32'd1 - 32'd1 + 32'(1'b0));
      @(negedge clk);
      chk("lat_c2", 32'(valid_out), 32'd1);
      @(posedge clk);
      #1;
    end
    chk("lat_drained", 32'(q.size()), 32'd0);

    // Every vector back to back with ready_in high.
    for (int i = 0; i < 20; i++) drive(i, i == 19);
    drain();

    // Random backpressure with occasional input gaps.
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            valid_in = 1'b0;
            @(posedge clk);
            #1;
          end
          drive(i, i == 19);
        end
        drain();
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk);
          #1;
          ready_in = ($urandom_range(0, 2) == 0);
        end
        ready_in = 1'b1;
      end
    join
    chk("bp_drained", 32'(q.size()), 32'd0);

    // Counter: three flagged deliveries among one clean one.
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    chk("cnt_clr", 32'(sat_count), 32'd0);
    drive(2, 1'b0);
    drive(0, 1'b0);
    drive(4, 1'b0);
    drive(5, 1'b0);
    drain();
    chk("cnt_three", 32'(sat_count), 32'd3);

    // Clear coincides with a fourth flagged delivery.
    drive(18, 1'b0);
    valid_in = 1'b0;
    for (int g = 0; g < 10; g++) begin
      @(negedge clk);
      if (valid_out) break;
    end
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    chk("cnt_clr_prio", 32'(sat_count), 32'd0);
    chk("cnt_clr_q", 32'(q.size()), 32'd0);

    for (int n = 0; n < 65535; n++) drive(5, 1'b0);
    drain();
    chk("cnt_full", 32'(sat_count), 32'h0000FFFF);
    for (int n = 0; n < 3; n++) drive(16, 1'b0);
    drain();
    chk("cnt_hold", 32'(sat_count), 32'h0000FFFF);

    // Reset with both stages occupied.
    ready_in = 1'b0;
    drive(0, 1'b0);
    drive(1, 1'b1);
    valid_in = 1'b0;
    @(negedge clk);
    chk("full_ready", 32'(ready_out), 32'd0);
    chk("full_valid", 32'(valid_out), 32'd1);
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("mid_rst_valid", 32'(valid_out), 32'd0);
    chk("mid_rst_data", output_data, 32'd0);
    chk("mid_rst_last", 32'(last_out), 32'd0);
    chk("mid_rst_sat", 32'(sat_out), 32'd0);
    chk("mid_rst_cnt", 32'(sat_count), 32'd0);
    chk("mid_rst_ready", 32'(ready_out), 32'd1);
    @(negedge clk);
    rst_n    = 1'b1;
    ready_in = 1'b1;
    for (int g = 0; g < 8; g++) begin
      @(negedge clk);
      chk("post_rst_idle", 32'(valid_out), 32'd0);
    end
    @(posedge clk);
    #1;
    drive(9, 1'b1);
    drain();
    chk("final_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp32_to_fixed_stage.md
# fp32_to_fixed_stage

Streaming front-end that converts IEEE-754 FP32 activations into saturated signed fixed-point words for the fixed-point Sigmoid datapath directly downstream. Sits between the tensor element stream and the Sigmoid operator. Provides a two-stage valid/ready pipeline with full backpressure, pass-through of a packet `last` marker, and a saturation event counter.

## Interface
Parameters:
- `FRAC_BITS`, default 16: fractional bits of the output; legal range 8..24.
- `CLAMP_INT`, default 8: output magnitude limit in integer units. Requires `CLAMP_INT << FRAC_BITS < 2^31`.

Ports (one clock, `clk`; reset `rst_n`, asynchronous, active-low):
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `valid_in` input 1: upstream element valid.
- `ready_out` output 1: this stage can accept an element.
- `input_data` input 32: FP32 element.
- `last_in` input 1: final element of the packet.
- `valid_out` output 1: converted element valid.
- `ready_in` input 1: downstream (Sigmoid) accepts.
- `output_data` output 32: two's-complement fixed-point, Q(32-FRAC_BITS).FRAC_BITS.
- `last_out` output 1: `last_in` delayed with its element.
- `sat_out` output 1: element was clamped or special (Inf/NaN).
- `clr_cnt` input 1: synchronous clear of `sat_count`.
- `sat_count` output 16: count of delivered elements with `sat_out`=1.

## Operation
- **Handshake:** a transfer occurs when valid and ready are both high on the rising edge of `clk`.
- **Input side:** `ready_out = !v1 || !v2 || ready_in`. This combinational path from `ready_in` is permitted.
- **Conversion:** value = (-1)^s × 1.m × 2^(e-127). The result is rounded to the nearest LSB of 2^-FRAC_BITS, with ties rounded away from zero.
- **Exponent cases:**
  - e==0 (zero or denormal): result 0, `sat_out`=0.
  - e==255 with m==0 (±Inf): result ±CLAMP, `sat_out`=1.
  - e==255 with m!=0 (NaN): result 0, `sat_out`=1.
- **Clamp:** if the rounded magnitude exceeds CLAMP = `CLAMP_INT << FRAC_BITS`, the result is ±CLAMP and `sat_out`=1. A magnitude exactly equal to CLAMP is not flagged. Shift amounts are clamped internally, so there is no out-of-range shift.
- **Negation:** the result is negated after rounding and clamping. -CLAMP is representable.
- **Counter:**
  - `sat_count` increments on each output transfer with `sat_out`=1.
  - It saturates at 0xFFFF.
  - `clr_cnt` has priority over a same-cycle increment; the result is 0.

## Timing
- **Reset values:** `valid_out`=0, `output_data`=0, `last_out`=0, `sat_out`=0, `sat_count`=0. Internal valids v1 and v2 are 0. `ready_out` is high immediately after reset.
- **Reset mid-operation:** all in-flight elements are discarded; no partial output appears after reset release.
- **Stage 1 (S1):** registers the sign, the aligned and rounded magnitude, the special flags, and `last`. It loads when `!v1 || s2_load`.
- **Stage 2 (S2):** clamps, negates and registers the outputs. It loads when `!v2 || ready_in`.
- **Latency:** 2 cycles from input transfer to `valid_out` when not stalled. Throughput is 1 element per cycle.
- **Stall:** while `valid_out && !ready_in`, `output_data`, `last_out` and `sat_out` hold stable. Two elements may be buffered, then `ready_out` drops.
- **Bubbles:** bubbles collapse. An empty S2 loads from S1 regardless of `ready_in`.
- **Simultaneous events:**
  - A transfer in and a transfer out in the same cycle must neither lose nor duplicate an element.
  - `clr_cnt` asserted together with a saturating transfer yields 0.

## Structure
- **Shared package `fp32_fixed_pkg`:** FP32 field widths and positions (sign 31, exponent 30:23, mantissa 22:0), `EXP_BIAS`=127, `EXP_SPECIAL`=8'hFF, and a packed struct for the S1 payload.
- **Sub-module `fp32_fixed_convert`:** purely combinational. It decodes the fields, aligns the mantissa, and rounds with special-case flags, and is instantiated in front of S1.
- **Top level:** the pipeline registers, the handshake logic, clamp and negate, and the counter.

## Test plan
With FRAC_BITS=16 and CLAMP_INT=8:
- **Basic values, `ready_in`=1:**
  - 0x3F800000 → 0x00010000, sat 0.
  - 0xC0200000 → 0xFFFD8000, sat 0.
  - Each output appears exactly 2 cycles after its input transfer.
- **Clamp and specials:**
  - 0x42C80000 (100.0) → 0x00080000, sat 1.
  - 0x41000000 (8.0) → 0x00080000, sat 0.
  - 0xFF800000 → 0xFFF80000, sat 1.
  - 0x7FC00000 → 0, sat 1.
- **Rounding:**
  - 0x37000000 (2^-17) → 0x00000001.
  - 0x36800000 (2^-18) → 0.
  - 0x00000001 (denormal) → 0, sat 0.
- **Backpressure:**
  - Stream 20 sequential values with a random `ready_in` pattern.
  - The output order, values and `last_out` on element 20 must match the model.
  - `ready_out` must be low only when both stages are full and `ready_in`=0.
- **Counter:**
  - Deliver 3 saturating elements, giving `sat_count`=3.
  - Assert `clr_cnt` in the same cycle as a 4th saturating transfer, giving 0.
  - Force the count to 0xFFFF via long saturating traffic; it must hold at 0xFFFF.
- **Reset:** assert `rst_n` low for 1 cycle with two elements in flight. All outputs must return to their reset values, and nothing may be emitted after release until new input arrives.
